mini_src_control_unit: RTL and testbench

- Hardwired Mini SRC control unit. Sequences the datapath through fetch (T0–T2) and opcode-specific execute steps (T3–T7).
- Drives the register-select, bus-drive, register-enable, memory and ALU-function controls of the datapath.
- Decodes `ir` and samples `con_ff` for branch resolution; provides `Run`/halt status to the top level.

---
 rtl/mini_src_pkg.sv | 131 +++++++++++++
 rtl/control_step_decode.sv | 141 ++++++++++++++
 rtl/mini_src_control_unit.sv | 111 +++++++++++
 tb/tb_mini_src_control_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mini_src_pkg.sv
// Shared definitions for the Mini SRC hardwired control unit: opcodes, ALU codes,
// sequencer states, control-bus bit positions and opcode classification helpers.
package mini_src_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_SHRA = 5'b01000;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01001;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b01010;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OP_W-1:0] OP_BR   = 5'b10011;
  localparam logic [OP_W-1:0] OP_JR   = 5'b10100;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b11000;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b11001;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  // The ALU function code space is the opcode space; address arithmetic uses ADD.
  localparam logic [OP_W-1:0] ALU_ADD = OP_ADD;

  typedef enum logic [3:0] {
    ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_WAIT, ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    CLS_RTYPE, CLS_IMM, CLS_LD, CLS_LDI, CLS_ST, CLS_MULDIV, CLS_UNARY,
    CLS_BR, CLS_JR, CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT
  } op_class_t;

  localparam int SRC_ROUT   = 8;
  localparam int SRC_BAOUT  = 7;
  localparam int SRC_COUT   = 6;
  localparam int SRC_POUT   = 5;
  localparam int SRC_MDROUT = 4;
  localparam int SRC_ZLOOUT = 3;
  localparam int SRC_ZHIOUT = 2;
  localparam int SRC_HIOUT  = 1;
  localparam int SRC_LOOUT  = 0;

  localparam int DST_RIN   = 9;
  localparam int DST_YEN   = 8;
  localparam int DST_ZLOEN = 7;
  localparam int DST_ZHIEN = 6;
  localparam int DST_MAREN = 5;
  localparam int DST_MDREN = 4;
  localparam int DST_IREN  = 3;
  localparam int DST_PEN   = 2;
  localparam int DST_HIEN  = 1;
  localparam int DST_LOEN  = 0;

  localparam int GR_A = 2;
  localparam int GR_B = 1;
  localparam int GR_C = 0;

  typedef struct packed {
    logic [OP_W-1:0] alu;
    logic [2:0]      gr;
    logic [8:0]      src;
    logic [9:0]      dst;
    logic            read;
    logic            write;
    logic            inc_pc;
    logic            con_in;
  } ctrl_t;

  // Undefined opcodes fall into the nop class so they simply refetch.
  function automatic op_class_t op_class(input logic [OP_W-1:0] op);
    op_class_t c;
    case (op)
      OP_LD:   c = CLS_LD;
      OP_LDI:  c = CLS_LDI;
      OP_ST:   c = CLS_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL:
               c = CLS_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI: c = CLS_IMM;
      OP_MUL, OP_DIV: c = CLS_MULDIV;
      OP_NEG, OP_NOT: c = CLS_UNARY;
      OP_BR:   c = CLS_BR;
      OP_JR:   c = CLS_JR;
      OP_MFHI: c = CLS_MFHI;
      OP_MFLO: c = CLS_MFLO;
      OP_HALT: c = CLS_HALT;
      default: c = CLS_NOP;
    endcase
    return c;
  endfunction

  function automatic state_t last_step(input op_class_t c);
    state_t s;
    case (c)
      CLS_RTYPE, CLS_IMM, CLS_LDI: s = ST_T5;
      CLS_LD, CLS_ST:              s = ST_T7;
      CLS_MULDIV, CLS_BR:          s = ST_T6;
      CLS_UNARY:                   s = ST_T4;
      CLS_JR, CLS_MFHI, CLS_MFLO:  s = ST_T3;
      default:                     s = ST_T2;
    endcase
    return s;
  endfunction

  function automatic state_t next_step(input state_t s);
    state_t n;
    case (s)
      ST_T0:   n = ST_T1;
      ST_T1:   n = ST_T2;
      ST_T2:   n = ST_T3;
      ST_T3:   n = ST_T4;
      ST_T4:   n = ST_T5;
      ST_T5:   n = ST_T6;
      ST_T6:   n = ST_T7;
      default: n = ST_T0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/control_step_decode.sv
// Combinational control-word decode for one sequencer state of the Mini SRC.
// RESET and HALT fall through to the all-zero word.
module control_step_decode
  import mini_src_pkg::*;
#(
  parameter int OPW = 5
) (
  input  state_t         state,
  input  logic [OPW-1:0] opcode,
  input  logic           con_ff,
  output ctrl_t          ctrl
);

  op_class_t cls;
  assign cls = op_class(opcode);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_T0: begin
        ctrl.src[SRC_POUT]   = 1'b1;
        ctrl.dst[DST_MAREN]  = 1'b1;
        ctrl.dst[DST_ZLOEN]  = 1'b1;
        ctrl.inc_pc          = 1'b1;
      end
      ST_WAIT: ctrl.read = 1'b1;
      ST_T1: begin
        ctrl.src[SRC_ZLOOUT] = 1'b1;
        ctrl.dst[DST_PEN]    = 1'b1;
        ctrl.dst[DST_MDREN]  = 1'b1;
        ctrl.read            = 1'b1;
      end
      ST_T2: begin
        ctrl.src[SRC_MDROUT] = 1'b1;
        ctrl.dst[DST_IREN]   = 1'b1;
      end
      ST_T3: begin
        case (cls)
          CLS_RTYPE, CLS_IMM: begin
            ctrl.gr[GR_B] = 1'b1; ctrl.src[SRC_ROUT] = 1'b1; ctrl.dst[DST_YEN] = 1'b1;
          end
          CLS_LD, CLS_LDI, CLS_ST: begin
            ctrl.gr[GR_B] = 1'b1; ctrl.src[SRC_BAOUT] = 1'b1; ctrl.dst[DST_YEN] = 1'b1;
          end
          CLS_MULDIV: begin
            ctrl.gr[GR_A] = 1'b1; ctrl.src[SRC_ROUT] = 1'b1; ctrl.dst[DST_YEN] = 1'b1;
          end
          CLS_UNARY: begin
            ctrl.gr[GR_B] = 1'b1; ctrl.src[SRC_ROUT] = 1'b1;
            ctrl.dst[DST_ZLOEN] = 1'b1; ctrl.alu = opcode;
          end
          CLS_BR: begin
            ctrl.gr[GR_A] = 1'b1; ctrl.src[SRC_ROUT] = 1'b1; ctrl.con_in = 1'b1;
          end
          CLS_JR: begin
            ctrl.gr[GR_A] = 1'b1; ctrl.src[SRC_ROUT] = 1'b1; ctrl.dst[DST_PEN] = 1'b1;
          end
          CLS_MFHI: begin
            ctrl.src[SRC_HIOUT] = 1'b1; ctrl.gr[GR_A] = 1'b1; ctrl.dst[DST_RIN] = 1'b1;
          end
          CLS_MFLO: begin
            ctrl.src[SRC_LOOUT] = 1'b1; ctrl.gr[GR_A] = 1'b1; ctrl.dst[DST_RIN] = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T4: begin
        case (cls)
          CLS_RTYPE: begin
            ctrl.gr[GR_C] = 1'b1; ctrl.src[SRC_ROUT] = 1'b1;
            ctrl.dst[DST_ZLOEN] = 1'b1; ctrl.alu = opcode;
          end
          CLS_IMM: begin
            ctrl.src[SRC_COUT] = 1'b1; ctrl.dst[DST_ZLOEN] = 1'b1; ctrl.alu = opcode;
          end
          CLS_LD, CLS_LDI, CLS_ST: begin
            ctrl.src[SRC_COUT] = 1'b1; ctrl.dst[DST_ZLOEN] = 1'b1; ctrl.alu = ALU_ADD;
          end
          CLS_MULDIV: begin
            ctrl.gr[GR_B] = 1'b1; ctrl.src[SRC_ROUT] = 1'b1; ctrl.alu = opcode;
            ctrl.dst[DST_ZLOEN] = 1'b1; ctrl.dst[DST_ZHIEN] = 1'b1;
          end
          CLS_UNARY: begin
            ctrl.src[SRC_ZLOOUT] = 1'b1; ctrl.gr[GR_A] = 1'b1; ctrl.dst[DST_RIN] = 1'b1;
          end
          CLS_BR: begin
            ctrl.src[SRC_POUT] = 1'b1; ctrl.dst[DST_YEN] = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T5: begin
        case (cls)
          CLS_RTYPE, CLS_IMM, CLS_LDI: begin
            ctrl.src[SRC_ZLOOUT] = 1'b1; ctrl.gr[GR_A] = 1'b1; ctrl.dst[DST_RIN] = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            ctrl.src[SRC_ZLOOUT] = 1'b1; ctrl.dst[DST_MAREN] = 1'b1;
          end
          CLS_MULDIV: begin
            ctrl.src[SRC_ZLOOUT] = 1'b1; ctrl.dst[DST_LOEN] = 1'b1;
          end
          CLS_BR: begin
            ctrl.src[SRC_COUT] = 1'b1; ctrl.dst[DST_ZLOEN] = 1'b1; ctrl.alu = ALU_ADD;
          end
          default: ;
        endcase
      end
      ST_T6: begin
        case (cls)
          CLS_LD: begin
            ctrl.read = 1'b1; ctrl.dst[DST_MDREN] = 1'b1;
          end
          CLS_ST: begin
            ctrl.gr[GR_A] = 1'b1; ctrl.src[SRC_ROUT] = 1'b1; ctrl.dst[DST_MDREN] = 1'b1;
          end
          CLS_MULDIV: begin
            ctrl.src[SRC_ZHIOUT] = 1'b1; ctrl.dst[DST_HIEN] = 1'b1;
          end
          CLS_BR: begin
            // A not-taken branch still spends T6, just with an idle bus.
            ctrl.src[SRC_ZLOOUT] = con_ff;
            ctrl.dst[DST_PEN]    = con_ff;
          end
          default: ;
        endcase
      end
      ST_T7: begin
        case (cls)
          CLS_LD: begin
            ctrl.src[SRC_MDROUT] = 1'b1; ctrl.gr[GR_A] = 1'b1; ctrl.dst[DST_RIN] = 1'b1;
          end
          CLS_ST: ctrl.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mini_src_control_unit.sv
// Mini SRC hardwired sequencer: fetch T0-T2, opcode-dependent execute T3-T7,
// optional memory WAIT step, and halt/reset handling.
module mini_src_control_unit
  import mini_src_pkg::*;
#(
  parameter int OPW      = 5,
  parameter int MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        stop,
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic [4:0]  alu_control,
  output logic [2:0]  gr_sel,
  output logic [8:0]  src_out,
  output logic [9:0]  dst_en,
  output logic        Read,
  output logic        Write,
  output logic        incPC,
  output logic        ConIn,
  output logic        Run,
  output logic [3:0]  step
);

  state_t         state_q, state_d;
  state_t         resume_q, resume_d;
  logic [OPW-1:0] opcode;
  logic           ir_unused;
  op_class_t      cls;
  ctrl_t          ctrl;

  assign opcode    = ir[31 -: OPW];
  assign ir_unused = ^ir[31-OPW:0];
  assign cls       = op_class(opcode);

  // WAIT is a shared extra Read cycle; resume_q remembers which step follows it.
  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    case (state_q)
      ST_RESET: state_d = ST_T0;
      ST_HALT:  state_d = ST_HALT;
      ST_WAIT:  state_d = resume_q;
      ST_T0: begin
        if (MEM_WAIT > 1) begin
          state_d  = ST_WAIT;
          resume_d = ST_T1;
        end else begin
          state_d = ST_T1;
        end
      end
      default: begin
        if (state_q == last_step(cls)) begin
          state_d = (cls == CLS_HALT || stop) ? ST_HALT : ST_T0;
        end else if (state_q == ST_T5 && cls == CLS_LD && MEM_WAIT > 1) begin
          state_d  = ST_WAIT;
          resume_d = ST_T6;
        end else begin
          state_d = next_step(state_q);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= ST_RESET;
      resume_q <= ST_T1;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
    end
  end

  control_step_decode #(
    .OPW (OPW)
  ) u_decode (
    .state  (state_q),
    .opcode (opcode),
    .con_ff (con_ff),
    .ctrl   (ctrl)
  );

  assign alu_control = ctrl.alu;
  assign gr_sel      = ctrl.gr;
  assign src_out     = ctrl.src;
  assign dst_en      = ctrl.dst;
  assign Read        = ctrl.read;
  assign Write       = ctrl.write;
  assign incPC       = ctrl.inc_pc;
  assign ConIn       = ctrl.con_in;
  assign Run         = (state_q != ST_RESET) && (state_q != ST_HALT);

  // WAIT reports step 8 so the extra memory cycle is visible on the debug port.
  always_comb begin
    case (state_q)
      ST_T0:   step = 4'd0;
      ST_T1:   step = 4'd1;
      ST_T2:   step = 4'd2;
      ST_T3:   step = 4'd3;
      ST_T4:   step = 4'd4;
      ST_T5:   step = 4'd5;
      ST_T6:   step = 4'd6;
      ST_T7:   step = 4'd7;
      ST_WAIT: step = 4'd8;
      default: step = 4'd0;
    endcase
  end

endmodule

// File: tb/tb_mini_src_control_unit.sv
// Scoreboard bench for mini_src_control_unit, run once with MEM_WAIT=1 and once with
// MEM_WAIT=2; each observed cycle is compared against a queued expected control word.
module tb_mini_src_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr_v  [2];
  logic        stop_v [2];
  logic        con_v  [2];
  logic [31:0] ir_v   [2];
  logic [4:0]  alu_w  [2];
  logic [2:0]  gr_w   [2];
  logic [8:0]  src_w  [2];
  logic [9:0]  dst_w  [2];
  logic        rd_w   [2];
  logic        wr_w   [2];
  logic        inc_w  [2];
  logic        cin_w  [2];
  logic        run_w  [2];
  logic [3:0]  step_w [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      mini_src_control_unit #(
        .OPW      (5),
        .MEM_WAIT (gi + 1)
      ) dut (
        .clk         (clk),
        .clr         (clr_v[gi]),
        .stop        (stop_v[gi]),
        .ir          (ir_v[gi]),
        .con_ff      (con_v[gi]),
        .alu_control (alu_w[gi]),
        .gr_sel      (gr_w[gi]),
        .src_out     (src_w[gi]),
        .dst_en      (dst_w[gi]),
        .Read        (rd_w[gi]),
        .Write       (wr_w[gi]),
        .incPC       (inc_w[gi]),
        .ConIn       (cin_w[gi]),
        .Run         (run_w[gi]),
        .step        (step_w[gi])
      );
    end
  endgenerate

  localparam logic [8:0] S_R = 9'h100, S_BA = 9'h080, S_C = 9'h040, S_P = 9'h020,
                         S_MDR = 9'h010, S_ZLO = 9'h008, S_ZHI = 9'h004,
                         S_HI = 9'h002, S_LO = 9'h001;
  localparam logic [9:0] D_RIN = 10'h200, D_Y = 10'h100, D_ZLO = 10'h080,
                         D_ZHI = 10'h040, D_MAR = 10'h020, D_MDR = 10'h010,
                         D_IR = 10'h008, D_PEN = 10'h004, D_HI = 10'h002, D_LO = 10'h001;
  localparam logic [2:0] G_A = 3'b100, G_B = 3'b010, G_C = 3'b001;
  localparam logic [3:0] M_RD = 4'b1000, M_WR = 4'b0100, M_INC = 4'b0010, M_CON = 4'b0001;
  localparam logic [35:0] ZERO = 36'd0;

  int          sel;
  int          errors = 0;
  int          checks = 0;
  logic [35:0] exp_q[$];
  string       tag_q[$];

  // Expected word layout: {step, Run, alu, gr, src, dst, Read, Write, incPC, ConIn}.
  function automatic logic [35:0] ex(input int st, input logic [2:0] gr, input logic [8:0] src,
                                     input logic [9:0] dst, input logic [4:0] alu,
                                     input logic [3:0] misc);
    logic [3:0] s4;
    s4 = st[3:0];
    return {s4, 1'b1, alu, gr, src, dst, misc};
  endfunction

  task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s (MEM_WAIT=%0d): got=%h want=%h", tag, sel + 1, got, want);
    end
  endtask

  task automatic push(input string tag, input logic [35:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic tick();
    logic [35:0] got;
    logic [35:0] want;
    string       t;
    @(posedge clk);
    @(negedge clk);
    got = {step_w[sel], run_w[sel], alu_w[sel], gr_w[sel], src_w[sel], dst_w[sel],
           rd_w[sel], wr_w[sel], inc_w[sel], cin_w[sel]};
    if (exp_q.size() == 0) begin
      check_eq("sb_underflow", 36'(exp_q.size()), 36'd1);
    end else begin
      want = exp_q.pop_front();
      t    = tag_q.pop_front();
      check_eq(t, got, want);
      check_eq({t, "/src_onehot"}, {35'd0, $countones(src_w[sel]) <= 1}, 36'd1);
      check_eq({t, "/rd_wr"}, {35'd0, rd_w[sel] & wr_w[sel]}, 36'd0);
    end
  endtask

  // ir changes only after T0 is observed, so the previous instruction's boundary
  // decision is never disturbed by the new opcode.
  task automatic go(input logic [31:0] w, input int stop_at, input int clr_at);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      tick();
      if (i == 0) ir_v[sel] = w;
      if (i == stop_at) stop_v[sel] = 1'b1;
      if (i == clr_at) clr_v[sel] = 1'b1;
    end
  endtask

  task automatic push_fetch(input string n);
    push({n, "/T0"}, ex(0, 3'b0, S_P, D_MAR | D_ZLO, 5'd0, M_INC));
    if (sel == 1) push({n, "/WAIT"}, ex(8, 3'b0, 9'd0, 10'd0, 5'd0, M_RD));
    push({n, "/T1"}, ex(1, 3'b0, S_ZLO, D_PEN | D_MDR, 5'd0, M_RD));
    push({n, "/T2"}, ex(2, 3'b0, S_MDR, D_IR, 5'd0, 4'd0));
  endtask

  task automatic push_mem_t3_t4(input string n);
    push({n, "/T3"}, ex(3, G_B, S_BA, D_Y, 5'd0, 4'd0));
    push({n, "/T4"}, ex(4, 3'b0, S_C, D_ZLO, 5'b00011, 4'd0));
  endtask

  task automatic do_br(input logic c);
    string n;
    n = c ? "br_taken" : "br_not";
    con_v[sel] = c;
    push_fetch(n);
    push({n, "/T3"}, ex(3, G_A, S_R, 10'd0, 5'd0, M_CON));
    push({n, "/T4"}, ex(4, 3'b0, S_P, D_Y, 5'd0, 4'd0));
    push({n, "/T5"}, ex(5, 3'b0, S_C, D_ZLO, 5'b00011, 4'd0));
    if (c) push({n, "/T6"}, ex(6, 3'b0, S_ZLO, D_PEN, 5'd0, 4'd0));
    else   push({n, "/T6"}, ex(6, 3'b0, 9'd0, 10'd0, 5'd0, 4'd0));
    go(32'h99000010, -1, -1);
  endtask

  task automatic leave_halt();
    clr_v[sel] = 1'b1;
    push("halt_clr", ZERO);
    go(ir_v[sel], -1, -1);
    clr_v[sel] = 1'b0;
  endtask

  task automatic run_suite();
    int f;
    f = 3 + sel;
    clr_v[sel] = 1'b1; stop_v[sel] = 1'b0; con_v[sel] = 1'b0; ir_v[sel] = 32'hD0000000;
    push("reset0", ZERO);
    push("reset1", ZERO);
    go(32'hD0000000, -1, -1);
    clr_v[sel] = 1'b0;

    push_fetch("add");
    push("add/T3", ex(3, G_B, S_R, D_Y, 5'd0, 4'd0));
    push("add/T4", ex(4, G_C, S_R, D_ZLO, 5'b00011, 4'd0));
    push("add/T5", ex(5, G_A, S_ZLO, D_RIN, 5'd0, 4'd0));
    go(32'h19888000, -1, -1);

    push_fetch("addi");
    push("addi/T3", ex(3, G_B, S_R, D_Y, 5'd0, 4'd0));
    push("addi/T4", ex(4, 3'b0, S_C, D_ZLO, 5'b01100, 4'd0));
    push("addi/T5", ex(5, G_A, S_ZLO, D_RIN, 5'd0, 4'd0));
    go(32'h61080005, -1, -1);

    push_fetch("ld");
    push_mem_t3_t4("ld");
    push("ld/T5", ex(5, 3'b0, S_ZLO, D_MAR, 5'd0, 4'd0));
    if (sel == 1) push("ld/WAIT", ex(8, 3'b0, 9'd0, 10'd0, 5'd0, M_RD));
    push("ld/T6", ex(6, 3'b0, 9'd0, D_MDR, 5'd0, M_RD));
    push("ld/T7", ex(7, G_A, S_MDR, D_RIN, 5'd0, 4'd0));
    go(32'h00900054, -1, -1);

    push_fetch("ldi");
    push_mem_t3_t4("ldi");
    push("ldi/T5", ex(5, G_A, S_ZLO, D_RIN, 5'd0, 4'd0));
    go(32'h08900054, -1, -1);

    push_fetch("st");
    push_mem_t3_t4("st");
    push("st/T5", ex(5, 3'b0, S_ZLO, D_MAR, 5'd0, 4'd0));
    push("st/T6", ex(6, G_A, S_R, D_MDR, 5'd0, 4'd0));
    push("st/T7", ex(7, 3'b0, 9'd0, 10'd0, 5'd0, M_WR));
    go(32'h10900054, -1, -1);

    do_br(1'b0);
    do_br(1'b1);

    push_fetch("mul");
    push("mul/T3", ex(3, G_A, S_R, D_Y, 5'd0, 4'd0));
    push("mul/T4", ex(4, G_B, S_R, D_ZLO | D_ZHI, 5'b01111, 4'd0));
    push("mul/T5", ex(5, 3'b0, S_ZLO, D_LO, 5'd0, 4'd0));
    push("mul/T6", ex(6, 3'b0, S_ZHI, D_HI, 5'd0, 4'd0));
    go(32'h79A00000, -1, -1);

    push_fetch("neg");
    push("neg/T3", ex(3, G_B, S_R, D_ZLO, 5'b10001, 4'd0));
    push("neg/T4", ex(4, G_A, S_ZLO, D_RIN, 5'd0, 4'd0));
    go(32'h88000000, -1, -1);

    push_fetch("jr");
    push("jr/T3", ex(3, G_A, S_R, D_PEN, 5'd0, 4'd0));
    go(32'hA0000000, -1, -1);

    push_fetch("mfhi");
    push("mfhi/T3", ex(3, G_A, S_HI, D_RIN, 5'd0, 4'd0));
    go(32'hC0000000, -1, -1);

    push_fetch("nop");
    go(32'hD0000000, -1, -1);
    push_fetch("undef");
    go(32'hF8000000, -1, -1);

    push_fetch("mul_clr");
    push("mul_clr/T3", ex(3, G_A, S_R, D_Y, 5'd0, 4'd0));
    push("mul_clr/T4", ex(4, G_B, S_R, D_ZLO | D_ZHI, 5'b01111, 4'd0));
    push("mul_clr/reset", ZERO);
    go(32'h79A00000, -1, f + 1);
    clr_v[sel] = 1'b0;

    push_fetch("add_stop");
    push("add_stop/T3", ex(3, G_B, S_R, D_Y, 5'd0, 4'd0));
    push("add_stop/T4", ex(4, G_C, S_R, D_ZLO, 5'b00011, 4'd0));
    push("add_stop/T5", ex(5, G_A, S_ZLO, D_RIN, 5'd0, 4'd0));
    push("add_stop/halt", ZERO);
    go(32'h19888000, f, -1);
    stop_v[sel] = 1'b0;
    push("add_stop/halt_hold", ZERO);
    go(ir_v[sel], -1, -1);
    leave_halt();

    push_fetch("halt_op");
    push("halt_op/halt", ZERO);
    push("halt_op/halt_hold", ZERO);
    go(32'hD8000000, -1, -1);
    leave_halt();

    push_fetch("after_halt");
    push("after_halt/T3", ex(3, G_A, S_LO, D_RIN, 5'd0, 4'd0));
    go(32'hC8000000, -1, -1);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      clr_v[k]  = 1'b1;
      stop_v[k] = 1'b0;
      con_v[k]  = 1'b0;
      ir_v[k]   = 32'hD0000000;
    end
    for (int s = 0; s < 2; s++) begin
      sel = s;
      run_suite();
      clr_v[s] = 1'b1;
    end
    check_eq("sb_drained", 36'(exp_q.size()), 36'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
